seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised Moore serial-pattern detector; successor to the fixed 8-bit detector.
//   Detects a length-N bit pattern on a 1-bit serial stream qualified by din_valid.
//   Pattern is run-time loadable; overlap mode is selectable; matches are counted.
//   Sits at the front of the serial link logic: it watches the recovered bit stream for framing words.
// PARAMETERS
//   N        8              pattern length in bits, 2..32
//   PATTERN  8'b1010_1010   reset-time pattern; PATTERN[N-1] is the first bit received
//   OVERLAP  1              1: a match may share bits with the next match; 0: restart from empty after a match
//   CNT_W    8              match counter width; the counter saturates
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-low reset
//   din        in   1      serial data bit
//   din_valid  in   1      din is sampled only when this is 1
//   pat_load   in   1      load pat_in as the new pattern
//   pat_in     in   N      new pattern (same bit order as PATTERN)
//   cnt_clr    in   1      synchronous clear of match_cnt
//   flag       out  1      registered Moore match flag
//   state_o    out  SW     current match length 0..N, SW = $clog2(N+1); debug output
//   match_cnt  out  CNT_W  saturating count of matches
// BEHAVIOUR
//   Reset (rst=0, async):
//     - state=0, history=0, pattern=PATTERN, flag=0, match_cnt=0.
//   State meaning:
//     - state k = length of the longest suffix of the accepted bits that equals pattern[N-1 -: k].
//     - k=N is the MATCH state.
//   Accepted bit (din_valid=1, pat_load=0):
//     - hist_next = {hist[N-2:0], din}.
//     - state_next = largest j <= N such that hist_next[j-1:0] == pattern[N-1 -: j], else 0.
//     - hist holds at most N bits.
//   Overlap rule, when the current state is N and the next bit is accepted:
//     - OVERLAP=1: the search runs over the full hist_next, so bits are shared.
//       With 10101010, a 1 goes to state 7 and a 0 goes to state 0.
//     - OVERLAP=0: history is treated as empty, so state_next = (din==pattern[N-1]) ? 1 : 0.
//   No accepted bit (din_valid=0): state and hist hold.
//   flag:
//     - flag <= (state==N) on every clock, so it lags MATCH entry by 1 cycle.
//     - It stays high for as long as the state remains N, including across din_valid=0 gaps.
//   match_cnt:
//     - Increments by 1 on the edge where the state goes from a value other than N to N.
//     - Holds at 2^CNT_W-1; does not wrap.
//     - cnt_clr=1 forces 0; cnt_clr wins over a simultaneous increment.
//   pat_load=1:
//     - pattern <= pat_in, state <= 0, hist <= 0.
//     - An accepted bit in the same cycle is discarded; flag follows its rule, so it falls on the next edge.
//   Reset asserted mid-pattern: all registers return to their reset values immediately; the partial match is lost.
//   All outputs are registered; no combinational path from an input to an output.
// STRUCTURE
//   Shared include file seq_det_defs.vh holds:
//     - default N, PATTERN and CNT_W;
//     - SW derivation macro;
//     - OVERLAP mode constants OVL_ON=1, OVL_OFF=0.
//   Sub-module seq_prefix_match (combinational, parameter N):
//     - inputs hist_next and pattern; output the longest suffix-prefix length, SW bits;
//     - priority search from j=N down to j=1.
//   Top level holds the state, hist, pattern, flag and counter registers plus the overlap/load muxing.
// TESTING
//   T1 defaults, OVERLAP=1, valid bits 1,0,1,0,1,0,1,0
//      -> state_o reaches 8 at bit 8; flag=1 the next cycle; match_cnt=1.
//   T2 after T1, feed 1,0 -> state 7 then 8; match_cnt=2; flag high again.
//      Repeat with OVERLAP=0: 1,0 -> state 1 then 2; no second match.
//   T3 T1 stream with din_valid=0 for 3 cycles after bit 5
//      -> state_o holds 5 through the gap; match completes 3 cycles later than in T1.
//   T4 pat_load with pat_in=8'b1100_0011 in the same cycle as an accepted bit
//      -> state_o=0 and that bit is ignored.
//      Then feed 1,1,0,0,0,0,1,1 -> flag; the old pattern 10101010 no longer matches.
//   T5 CNT_W=2, 5 back-to-back matches -> match_cnt reads 1,2,3,3,3.
//      cnt_clr together with an increment -> match_cnt=0.
//   T6 drop rst low asynchronously between clock edges at state 6
//      -> state_o=0, flag=0, match_cnt=0 at once; pattern returns to PATTERN.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial-pattern detector.
// Defaults for N/PATTERN/CNT_W, overlap mode codes, state-width helper.
package seq_det_pkg;

    localparam int         DEF_N       = 8;
    localparam logic [7:0] DEF_PATTERN = 8'b1010_1010;
    localparam int         DEF_CNT_W   = 8;

    localparam int OVL_ON  = 1;
    localparam int OVL_OFF = 0;

    // Width needed to hold a match length 0..n.
    function automatic int sw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Longest suffix of hist that equals a prefix (MSB-first) of pattern.
// Ports: hist, pattern (N bits) in; len (SW bits) out. Combinational.
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int SW = sw_of(N)
) (
    input  logic [N-1:0]  hist,
    input  logic [N-1:0]  pattern,
    output logic [SW-1:0] len
);

    logic ok;
    logic found;

    // hist[j-1:0] == pattern[N-1 -: j], longest j wins.
    always_comb begin
        len   = '0;
        found = 1'b0;
        ok    = 1'b0;
        for (int j = N; j >= 1; j--) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (hist[i] != pattern[N-j+i]) begin
                    ok = 1'b0;
                end
            end
            if (ok && !found) begin
                len   = SW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with loadable pattern and match counter.
// Ports: clk, rst (async low), din, din_valid, pat_load, pat_in, cnt_clr;
//        flag, state_o, match_cnt (all registered).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int           N       = DEF_N,
    parameter logic [N-1:0] PATTERN = N'(DEF_PATTERN),
    parameter int           OVERLAP = OVL_ON,
    parameter int           CNT_W   = DEF_CNT_W,
    localparam int          SW      = sw_of(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [SW-1:0]    state_o,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [SW-1:0] FULL = SW'(N);

    logic [SW-1:0] state;
    logic [SW-1:0] state_n;
    logic [SW-1:0] srch_len;
    logic [N-1:0]  hist;
    logic [N-1:0]  hist_n;
    logic [N-1:0]  hist_acc;
    logic [N-1:0]  pattern;
    logic          hit;

    assign hist_acc = {hist[N-2:0], din};

    seq_prefix_match #(
        .N  (N),
        .SW (SW)
    ) u_match (
        .hist    (hist_acc),
        .pattern (pattern),
        .len     (srch_len)
    );

    always_comb begin
        state_n = state;
        hist_n  = hist;
        if (pat_load) begin
            state_n = '0;
            hist_n  = '0;
        end else if (din_valid) begin
            if (state == FULL && OVERLAP == OVL_OFF) begin
                // Non-overlap: the completed match is forgotten.
                hist_n  = {{(N-1){1'b0}}, din};
                state_n = (din == pattern[N-1]) ? SW'(1) : '0;
            end else begin
                hist_n  = hist_acc;
                state_n = srch_len;
            end
        end
    end

    // Count only on entry into the match state.
    assign hit = (state != FULL) && (state_n == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= '0;
            hist      <= '0;
            pattern   <= PATTERN;
            flag      <= 1'b0;
            match_cnt <= '0;
        end else begin
            state <= state_n;
            hist  <= hist_n;
            flag  <= (state == FULL);
            if (pat_load) begin
                pattern <= pat_in;
            end
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (hit && match_cnt != '1) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap, gaps, load, saturation,
// async reset; three instances share one stimulus stream.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       pat_load = 1'b0;
    logic [7:0] pat_in = 8'h00;
    logic       cnt_clr = 1'b0;

    logic       flag_a, flag_b, flag_c;
    logic [3:0] state_a, state_b, state_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param u_ov (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .flag(flag_a), .state_o(state_a), .match_cnt(cnt_a)
    );

    seq_detector_param #(.OVERLAP(0)) u_no (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .flag(flag_b), .state_o(state_b), .match_cnt(cnt_b)
    );

    seq_detector_param #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .flag(flag_c), .state_o(state_c), .match_cnt(cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge; return 1 unit after the rise.
    task automatic step(input logic d, input logic v,
                        input logic ld, input logic clr);
        @(negedge clk);
        din       = d;
        din_valid = v;
        pat_load  = ld;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic d);
        step(d, 1'b1, 1'b0, 1'b0);
    endtask

    logic [7:0] seq;
    logic [7:0] seq2;

    initial begin
        // reset state
        #3;
        chk("rst_state", 32'(state_a), 32'd0);
        chk("rst_flag", 32'(flag_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_cnt_c2", 32'(cnt_c), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // T1: 10101010 from empty, state climbs 1..8
        seq = 8'b1010_1010;
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq[i]);
            chk("t1_state", 32'(state_a), 32'(8 - i));
        end
        chk("t1_flag_lag", 32'(flag_a), 32'd0);
        chk("t1_cnt", 32'(cnt_a), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_flag", 32'(flag_a), 32'd1);
        chk("t1_hold", 32'(state_a), 32'd8);
        chk("t1_flag_no", 32'(flag_b), 32'd1);

        // T2: overlap vs non-overlap continuation
        bit_in(1'b1);
        chk("t2_ov_st7", 32'(state_a), 32'd7);
        chk("t2_no_st1", 32'(state_b), 32'd1);
        chk("t2_flag_hi", 32'(flag_a), 32'd1);
        bit_in(1'b0);
        chk("t2_ov_st8", 32'(state_a), 32'd8);
        chk("t2_no_st2", 32'(state_b), 32'd2);
        chk("t2_ov_cnt", 32'(cnt_a), 32'd2);
        chk("t2_no_cnt", 32'(cnt_b), 32'd1);
        chk("t5_cnt_2", 32'(cnt_c), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_flag_again", 32'(flag_a), 32'd1);

        // T5: saturation of the 2-bit counter
        for (int k = 3; k <= 5; k++) begin
            bit_in(1'b1);
            bit_in(1'b0);
            chk("t5_cnt_c2", 32'(cnt_c), (k > 3) ? 32'd3 : 32'(k));
            chk("t5_cnt_8b", 32'(cnt_a), 32'(k));
        end
        bit_in(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_clr_c2", 32'(cnt_c), 32'd0);
        chk("t5_clr_8b", 32'(cnt_a), 32'd0);
        chk("t5_clr_st", 32'(state_a), 32'd8);

        // T3: async reset, then a 3-cycle valid gap after bit 5
        rst = 1'b0;
        #1;
        chk("t3_rst_st", 32'(state_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 7; i >= 3; i--) begin
            bit_in(seq[i]);
        end
        chk("t3_st5", 32'(state_a), 32'd5);
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            chk("t3_gap_st", 32'(state_a), 32'd5);
        end
        for (int i = 2; i >= 0; i--) begin
            bit_in(seq[i]);
            chk("t3_state", 32'(state_a), 32'(8 - i));
        end
        chk("t3_cnt", 32'(cnt_a), 32'd1);

        // T4: load a new pattern alongside an accepted bit
        pat_in = 8'b1100_0011;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_load_st", 32'(state_a), 32'd0);
        chk("t4_load_flag", 32'(flag_a), 32'd1);
        seq2 = 8'b1100_0011;
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq2[i]);
            chk("t4_state", 32'(state_a), 32'(8 - i));
        end
        chk("t4_cnt", 32'(cnt_a), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_flag", 32'(flag_a), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq[i]);
        end
        chk("t4_old_st", 32'(state_a), 32'd0);
        chk("t4_old_cnt", 32'(cnt_a), 32'd2);
        chk("t4_old_flag", 32'(flag_a), 32'd0);

        // T6: async reset between edges at state 6
        for (int i = 7; i >= 2; i--) begin
            bit_in(seq2[i]);
        end
        chk("t6_st6", 32'(state_a), 32'd6);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_st", 32'(state_a), 32'd0);
        chk("t6_rst_flag", 32'(flag_a), 32'd0);
        chk("t6_rst_cnt", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bit_in(seq[i]);
        end
        chk("t6_pat_back", 32'(state_a), 32'd8);
        chk("t6_cnt", 32'(cnt_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
